// File: rtl/combat_pkg.sv
// rtl/combat_pkg.sv - attack/hit/winner codes and FSM state for combat_resolver; COMBAT_BLOCK_EN enables BLOCK
package combat_pkg;

    localparam logic [3:0] ATK_STANDBY = 4'b0000;
    localparam logic [3:0] ATK_LIGHT   = 4'b0001;
    localparam logic [3:0] ATK_HEAVY   = 4'b0010;
    localparam logic [3:0] ATK_BLOCK   = 4'b0011;

    localparam logic [1:0] HIT_NONE     = 2'b00;
    localparam logic [1:0] HIT_CRITICAL = 2'b01;
    localparam logic [1:0] HIT_NORMAL   = 2'b10;
    localparam logic [1:0] HIT_MISS     = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_CPU  = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIGHT = 2'b01,
        ST_OVER  = 2'b10
    } state_t;

    // Types that consume a ready slot; anything else is treated like STANDBY.
    function automatic logic attack_known(input logic [3:0] t);
`ifdef COMBAT_BLOCK_EN
        return (t == ATK_LIGHT) || (t == ATK_HEAVY) || (t == ATK_BLOCK);
`else
        return (t == ATK_LIGHT) || (t == ATK_HEAVY);
`endif
    endfunction

endpackage

// File: rtl/combat_damage_calc.sv
// rtl/combat_damage_calc.sv - one attacker's damage and the defender's saturated health
module combat_damage_calc
    import combat_pkg::*;
#(
    parameter int HP_W       = 8,
    parameter int LIGHT_DMG  = 1,
    parameter int HEAVY_DMG  = 2,
    parameter int CRIT_SHIFT = 1
) (
    input  logic            accept_i,
    input  logic [3:0]      type_i,
    input  logic [1:0]      state_i,
    input  logic            halve_i,
    input  logic [HP_W-1:0] health_i,
    output logic            dmg_nz_o,
    output logic [HP_W-1:0] health_o
);

    logic [31:0] base;
    logic [31:0] dmg_raw;
    logic [31:0] dmg;

    always_comb begin
        base = '0;
        if (accept_i) begin
            case (type_i)
                ATK_LIGHT: base = LIGHT_DMG;
                ATK_HEAVY: base = HEAVY_DMG;
                default:   base = '0;
            endcase
        end

        case (state_i)
            HIT_CRITICAL: dmg_raw = base << CRIT_SHIFT;
            HIT_NORMAL:   dmg_raw = base;
            default:      dmg_raw = '0;
        endcase

        dmg      = halve_i ? (dmg_raw >> 1) : dmg_raw;
        dmg_nz_o = (dmg != '0);

        // Compare at full width so oversized damage can never wrap the health register.
        if (dmg >= 32'(health_i)) begin
            health_o = '0;
        end else begin
            health_o = health_i - dmg[HP_W-1:0];
        end
    end

endmodule

// File: rtl/combat_resolver.sv
// rtl/combat_resolver.sv - two-fighter damage resolver and game FSM; COMBAT_BLOCK_EN enables BLOCK
module combat_resolver
    import combat_pkg::*;
#(
    parameter int HP_W           = 8,
    parameter int HP_MAX         = 100,
    parameter int LIGHT_DMG      = 1,
    parameter int HEAVY_DMG      = 2,
    parameter int CRIT_SHIFT     = 1,
    parameter int HEAVY_COOLDOWN = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_p1_valid,
    input  logic [3:0]      i_p1_type,
    input  logic [1:0]      i_p1_state,
    input  logic            i_cpu_valid,
    input  logic [3:0]      i_cpu_type,
    input  logic [1:0]      i_cpu_state,
    output logic [HP_W-1:0] o_p1_health,
    output logic [HP_W-1:0] o_cpu_health,
    output logic            o_p1_ready,
    output logic            o_cpu_ready,
    output logic            o_p1_attacking,
    output logic            o_cpu_attacking,
    output logic            o_game_over,
    output logic [1:0]      o_winner
);

    localparam int              CD_W    = $clog2(HEAVY_COOLDOWN + 2);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(HEAVY_COOLDOWN);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [HP_W-1:0] HP_INIT = HP_W'(HP_MAX);

    state_t          state_q, state_d;
    logic [HP_W-1:0] p1_hp_q, p1_hp_d, cpu_hp_q, cpu_hp_d;
    logic [CD_W-1:0] p1_cd_q, p1_cd_d, cpu_cd_q, cpu_cd_d;
    logic            p1_atk_q, p1_atk_d, cpu_atk_q, cpu_atk_d;
    logic [1:0]      winner_q, winner_d;

    logic            fighting;
    logic            p1_accept, cpu_accept;
    logic            p1_blocking, cpu_blocking;
    logic            p1_hit, cpu_hit;
    logic [HP_W-1:0] p1_hp_hit, cpu_hp_hit;
    logic            any_zero;

    assign fighting   = (state_q == ST_FIGHT);
    assign p1_accept  = o_p1_ready  && i_p1_valid  && attack_known(i_p1_type);
    assign cpu_accept = o_cpu_ready && i_cpu_valid && attack_known(i_cpu_type);

`ifdef COMBAT_BLOCK_EN
    assign p1_blocking  = p1_accept  && (i_p1_type  == ATK_BLOCK);
    assign cpu_blocking = cpu_accept && (i_cpu_type == ATK_BLOCK);
`else
    assign p1_blocking  = 1'b0;
    assign cpu_blocking = 1'b0;
`endif

    combat_damage_calc #(
        .HP_W(HP_W), .LIGHT_DMG(LIGHT_DMG), .HEAVY_DMG(HEAVY_DMG), .CRIT_SHIFT(CRIT_SHIFT)
    ) u_p1_strike (
        .accept_i (p1_accept),
        .type_i   (i_p1_type),
        .state_i  (i_p1_state),
        .halve_i  (cpu_blocking),
        .health_i (cpu_hp_q),
        .dmg_nz_o (p1_hit),
        .health_o (cpu_hp_hit)
    );

    combat_damage_calc #(
        .HP_W(HP_W), .LIGHT_DMG(LIGHT_DMG), .HEAVY_DMG(HEAVY_DMG), .CRIT_SHIFT(CRIT_SHIFT)
    ) u_cpu_strike (
        .accept_i (cpu_accept),
        .type_i   (i_cpu_type),
        .state_i  (i_cpu_state),
        .halve_i  (p1_blocking),
        .health_i (p1_hp_q),
        .dmg_nz_o (cpu_hit),
        .health_o (p1_hp_hit)
    );

    assign any_zero = (p1_hp_hit == '0) || (cpu_hp_hit == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_FIGHT;
            ST_FIGHT: begin
                if (i_start)       state_d = ST_FIGHT;
                else if (any_zero) state_d = ST_OVER;
            end
            ST_OVER:  if (i_start) state_d = ST_FIGHT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_p1_ready  = fighting && (p1_cd_q == '0);
        o_cpu_ready = fighting && (cpu_cd_q == '0);
        o_game_over = (state_q == ST_OVER);
    end

    always_comb begin
        p1_hp_d   = p1_hp_q;
        cpu_hp_d  = cpu_hp_q;
        p1_cd_d   = (p1_cd_q  != '0) ? p1_cd_q  - CD_ONE : p1_cd_q;
        cpu_cd_d  = (cpu_cd_q != '0) ? cpu_cd_q - CD_ONE : cpu_cd_q;
        p1_atk_d  = 1'b0;
        cpu_atk_d = 1'b0;
        winner_d  = winner_q;

        // A start in any state wins over whatever attacks arrive alongside it.
        if (i_start) begin
            p1_hp_d  = HP_INIT;
            cpu_hp_d = HP_INIT;
            p1_cd_d  = '0;
            cpu_cd_d = '0;
            winner_d = WIN_NONE;
        end else if (fighting) begin
            p1_hp_d   = p1_hp_hit;
            cpu_hp_d  = cpu_hp_hit;
            p1_atk_d  = p1_hit;
            cpu_atk_d = cpu_hit;
            if (p1_accept && (i_p1_type == ATK_HEAVY))   p1_cd_d  = CD_LOAD;
            if (cpu_accept && (i_cpu_type == ATK_HEAVY)) cpu_cd_d = CD_LOAD;
            if (any_zero) winner_d = {p1_hp_hit == '0, cpu_hp_hit == '0};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            p1_hp_q   <= HP_INIT;
            cpu_hp_q  <= HP_INIT;
            p1_cd_q   <= '0;
            cpu_cd_q  <= '0;
            p1_atk_q  <= 1'b0;
            cpu_atk_q <= 1'b0;
            winner_q  <= WIN_NONE;
        end else begin
            p1_hp_q   <= p1_hp_d;
            cpu_hp_q  <= cpu_hp_d;
            p1_cd_q   <= p1_cd_d;
            cpu_cd_q  <= cpu_cd_d;
            p1_atk_q  <= p1_atk_d;
            cpu_atk_q <= cpu_atk_d;
            winner_q  <= winner_d;
        end
    end

    assign o_p1_health     = p1_hp_q;
    assign o_cpu_health    = cpu_hp_q;
    assign o_p1_attacking  = p1_atk_q;
    assign o_cpu_attacking = cpu_atk_q;
    assign o_winner        = winner_q;

endmodule
